// File: rtl/wb_daq_sample_buffer.sv
// Packs 8/16/32-bit ADC samples into 32-bit words, queues them, and requests Wishbone write bursts.
// Push and pop show up one cycle after the accepting edge; a push into a full FIFO is dropped and counted.
module wb_daq_sample_buffer #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int FIFO_AW = 4
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               enable,
  input  logic [1:0]         data_size,
  input  logic               adc_valid,
  input  logic [31:0]        adc_data,
  input  logic               flush,
  input  logic [aw-1:0]      vector_base,
  input  logic [FIFO_AW:0]   threshold,
  input  logic               bus_master_idle,
  input  logic               data_done,
  output logic               start,
  output logic [aw-1:0]      address,
  output logic [3:0]         selection,
  output logic               write,
  output logic [dw-1:0]      data_wr,
  output logic               fifo_empty,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic [15:0]        dropped_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_LVL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]         slot;
  logic [1:0]         last_slot;
  logic [31:0]        acc;
  logic [31:0]        placed;
  logic [dw-1:0]      push_dat;
  logic               sample_in, word_full, push, pop, push_ok;
  logic [FIFO_AW:0]   level_nxt;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_inc;
  logic [dw-1:0]      mem [DEPTH];
  logic [1:0]         state;
  logic               flush_pending;
  logic [FIFO_AW:0]   eff_thr;
  logic               go;

  // Packer: sample k of a word lands in lane k, little-endian.
  always_comb begin
    placed    = '0;
    last_slot = 2'd0;
    case (data_size)
      2'd0: begin
        placed    = {24'd0, adc_data[7:0]} << {slot, 3'b000};
        last_slot = 2'd3;
      end
      2'd1: begin
        placed    = {16'd0, adc_data[15:0]} << {slot[0], 4'b0000};
        last_slot = 2'd1;
      end
      default: placed = adc_data;
    endcase
  end

  assign sample_in = enable && adc_valid;
  assign word_full = sample_in && (slot == last_slot);
  assign push      = word_full || (enable && flush && (slot != 2'd0 || sample_in));
  assign push_dat  = acc | (sample_in ? placed : 32'd0);

  always_ff @(posedge wb_clk) begin
    if (wb_rst || !enable || push) begin
      slot <= 2'd0;
      acc  <= 32'd0;
    end else if (sample_in) begin
      slot <= slot + 2'd1;
      acc  <= push_dat;
    end
  end

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign pop     = data_done && (fifo_level != '0);
  assign push_ok = push && ((fifo_level != FULL_LVL) || pop);
  assign rd_inc  = rd_ptr + PTR_ONE;

  always_comb begin
    level_nxt = fifo_level;
    if (push_ok && !pop)      level_nxt = fifo_level + LVL_ONE;
    else if (!push_ok && pop) level_nxt = fifo_level - LVL_ONE;
  end

  always_ff @(posedge wb_clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      fifo_empty    <= 1'b1;
      data_wr       <= '0;
      overflow      <= 1'b0;
      dropped_count <= 16'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_inc;
      fifo_level <= level_nxt;
      fifo_empty <= (level_nxt == '0);
      // The incoming word bypasses memory when it becomes the new head.
      if (push_ok && ((fifo_level == '0) || (pop && fifo_level == LVL_ONE)))
        data_wr <= push_dat;
      else if (pop)
        data_wr <= mem[rd_inc];
      if (push && !push_ok) begin
        overflow <= 1'b1;
        if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
      end
    end
  end

  assign eff_thr = (threshold == '0) ? LVL_ONE : threshold;
  assign go = enable && bus_master_idle && !fifo_empty &&
              ((fifo_level >= eff_thr) || flush_pending);
  assign start = (state == S_REQ);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state         <= S_IDLE;
      flush_pending <= 1'b0;
      address       <= '0;
      selection     <= 4'h0;
      write         <= 1'b0;
    end else begin
      if (flush)               flush_pending <= 1'b1;
      else if (state == S_REQ) flush_pending <= 1'b0;
      case (state)
        S_IDLE: if (go) begin
          state     <= S_REQ;
          address   <= vector_base;
          selection <= 4'hF;
          write     <= 1'b1;
        end
        S_REQ:   state <= S_BURST;
        S_BURST: if (bus_master_idle) state <= S_HOLD;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_daq_sample_buffer.sv
// Self-checking bench: directed vector table, hand-written burst/overflow/reset sequences, randomized queue model.
module tb_wb_daq_sample_buffer;

  localparam logic [31:0] BASE = 32'h1000_0040;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic        adc_valid = 1'b0;
  logic [31:0] adc_data = 32'd0;
  logic        flush = 1'b0;
  logic [31:0] vector_base = BASE;
  logic [4:0]  threshold = 5'd1;
  logic        bus_master_idle = 1'b1;
  logic        data_done = 1'b0;
  logic        start;
  logic [31:0] address;
  logic [3:0]  selection;
  logic        write;
  logic [31:0] data_wr;
  logic        fifo_empty;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] dropped_count;

  int checks = 0;
  int errors = 0;

  wb_daq_sample_buffer dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .data_size(data_size),
    .adc_valid(adc_valid), .adc_data(adc_data), .flush(flush), .vector_base(vector_base),
    .threshold(threshold), .bus_master_idle(bus_master_idle), .data_done(data_done),
    .start(start), .address(address), .selection(selection), .write(write),
    .data_wr(data_wr), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
    .overflow(overflow), .dropped_count(dropped_count)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic        en;
    logic [1:0]  sz;
    logic [4:0]  thr;
    logic        vld;
    logic [31:0] dat;
    logic        fl;
    logic        dn;
    logic        idle;
    logic        exp_start;
    logic [4:0]  exp_lvl;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic en, logic [1:0] sz, logic [4:0] thr, logic vld,
                             logic [31:0] dat, logic fl, logic dn, logic idle,
                             logic st, logic [4:0] lvl, logic [31:0] wd);
    vec_t r;
    r.en = en; r.sz = sz; r.thr = thr; r.vld = vld; r.dat = dat; r.fl = fl;
    r.dn = dn; r.idle = idle; r.exp_start = st; r.exp_lvl = lvl; r.exp_dat = wd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " start"}, 32'(start), 32'd0);
    chk({tag, " address"}, address, 32'd0);
    chk({tag, " selection"}, 32'(selection), 32'd0);
    chk({tag, " write"}, 32'(write), 32'd0);
    chk({tag, " data_wr"}, data_wr, 32'd0);
    chk({tag, " fifo_empty"}, 32'(fifo_empty), 32'd1);
    chk({tag, " fifo_level"}, 32'(fifo_level), 32'd0);
    chk({tag, " overflow"}, 32'(overflow), 32'd0);
    chk({tag, " dropped_count"}, 32'(dropped_count), 32'd0);
  endtask

  task automatic do_reset();
    wb_rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; flush = 1'b0; data_done = 1'b0;
    tick();
    wb_rst = 1'b0;
  endtask

  // Reference model state for the random phase.
  logic [31:0] m_q[$];
  logic [31:0] m_pend[$];
  logic        m_ovf;
  int          m_drop;

  task automatic model_step(input logic en, input logic [1:0] sz, input logic vld,
                            input logic [31:0] dat, input logic fl, input logic dn);
    int bits, n;
    logic [63:0] mask, word;
    if (dn && m_q.size() > 0) void'(m_q.pop_front());
    if (!en) begin
      m_pend.delete();
      return;
    end
    bits = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    n    = 32 / bits;
    if (vld) m_pend.push_back(dat);
    if (m_pend.size() == n || (fl && m_pend.size() > 0)) begin
      mask = (64'd1 << bits) - 64'd1;
      word = 64'd0;
      foreach (m_pend[i]) word |= (64'(m_pend[i]) & mask) << (bits * i);
      if (m_q.size() < 16) m_q.push_back(word[31:0]);
      else begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
      m_pend.delete();
    end
  endtask

  initial begin
    int starts, busy, since_idle;
    logic [31:0] exp_head[$];

    tick(); tick();
    chk_reset_outputs("reset");
    wb_rst = 1'b0;

    // 8-bit, threshold 1: one packed word, one burst, one pop
    tbl.push_back(v(1,0,1,1,'h11,0,0,1, 0,0,0));
    tbl.push_back(v(1,0,1,1,'h22,0,0,1, 0,0,0));
    tbl.push_back(v(1,0,1,1,'h33,0,0,1, 0,0,0));
    tbl.push_back(v(1,0,1,1,'h44,0,0,1, 0,1,'h44332211));
    tbl.push_back(v(1,0,1,0,0,0,0,1,    1,1,'h44332211));
    tbl.push_back(v(1,0,1,0,0,0,0,0,    0,1,'h44332211));
    tbl.push_back(v(1,0,1,0,0,0,1,0,    0,0,0));
    tbl.push_back(v(1,0,1,0,0,0,0,1,    0,0,0));
    tbl.push_back(v(1,0,1,0,0,0,0,1,    0,0,0));
    // 16-bit, threshold 2
    tbl.push_back(v(0,1,2,0,0,0,0,1,        0,0,0));
    tbl.push_back(v(1,1,2,1,'hAAAA,0,0,1,   0,0,0));
    tbl.push_back(v(1,1,2,1,'hBBBB,0,0,1,   0,1,'hBBBBAAAA));
    tbl.push_back(v(1,1,2,0,0,0,0,1,        0,1,'hBBBBAAAA));
    tbl.push_back(v(1,1,2,1,'hCCCC,0,0,1,   0,1,'hBBBBAAAA));
    tbl.push_back(v(1,1,2,1,'hDDDD,0,0,1,   0,2,'hBBBBAAAA));
    tbl.push_back(v(1,1,2,0,0,0,0,1,        1,2,'hBBBBAAAA));
    tbl.push_back(v(1,1,2,0,0,0,0,0,        0,2,'hBBBBAAAA));
    tbl.push_back(v(1,1,2,0,0,0,1,0,        0,1,'hDDDDCCCC));
    tbl.push_back(v(1,1,2,0,0,0,1,0,        0,0,0));
    tbl.push_back(v(1,1,2,0,0,0,0,1,        0,0,0));
    tbl.push_back(v(1,1,2,0,0,0,0,1,        0,0,0));
    // 8-bit partial word flushed, threshold 8
    tbl.push_back(v(0,0,8,0,0,0,0,1,      0,0,0));
    tbl.push_back(v(1,0,8,1,'h01,0,0,1,   0,0,0));
    tbl.push_back(v(1,0,8,1,'h02,0,0,1,   0,0,0));
    tbl.push_back(v(1,0,8,1,'h03,0,0,1,   0,0,0));
    tbl.push_back(v(1,0,8,0,0,1,0,1,      0,1,'h00030201));
    tbl.push_back(v(1,0,8,0,0,0,0,1,      1,1,'h00030201));
    tbl.push_back(v(1,0,8,0,0,0,0,0,      0,1,'h00030201));
    tbl.push_back(v(1,0,8,0,0,0,1,0,      0,0,0));
    tbl.push_back(v(1,0,8,0,0,0,0,1,      0,0,0));
    tbl.push_back(v(1,0,8,0,0,0,0,1,      0,0,0));
    // flush on an empty packer pushes nothing; flush with the final sample pushes one word
    tbl.push_back(v(1,0,8,0,0,1,0,1,      0,0,0));
    tbl.push_back(v(1,0,8,1,'hA1,0,0,1,   0,0,0));
    tbl.push_back(v(1,0,8,1,'hA2,0,0,1,   0,0,0));
    tbl.push_back(v(1,0,8,1,'hA3,0,0,1,   0,0,0));
    tbl.push_back(v(1,0,8,1,'hA4,1,0,1,   0,1,'hA4A3A2A1));
    tbl.push_back(v(1,0,8,0,0,0,0,1,      1,1,'hA4A3A2A1));
    tbl.push_back(v(1,0,8,0,0,0,0,0,      0,1,'hA4A3A2A1));
    tbl.push_back(v(1,0,8,0,0,0,1,0,      0,0,0));
    tbl.push_back(v(1,0,8,0,0,0,0,1,      0,0,0));
    tbl.push_back(v(1,0,8,0,0,0,0,1,      0,0,0));

    foreach (tbl[i]) begin
      enable = tbl[i].en; data_size = tbl[i].sz; threshold = tbl[i].thr;
      adc_valid = tbl[i].vld; adc_data = tbl[i].dat; flush = tbl[i].fl;
      data_done = tbl[i].dn; bus_master_idle = tbl[i].idle;
      tick();
      chk($sformatf("vec%0d start", i), 32'(start), 32'(tbl[i].exp_start));
      chk($sformatf("vec%0d level", i), 32'(fifo_level), 32'(tbl[i].exp_lvl));
      chk($sformatf("vec%0d empty", i), 32'(fifo_empty), 32'(tbl[i].exp_lvl == 0));
      if (tbl[i].exp_lvl != 0) chk($sformatf("vec%0d data_wr", i), data_wr, tbl[i].exp_dat);
      if (tbl[i].exp_start) begin
        chk($sformatf("vec%0d address", i), address, BASE);
        chk($sformatf("vec%0d selection", i), 32'(selection), 32'hF);
        chk($sformatf("vec%0d write", i), 32'(write), 32'd1);
      end
    end
    adc_valid = 0; flush = 0; data_done = 0;

    // Overflow: 18 words into a 16-deep FIFO with the master busy
    enable = 0; data_size = 2'd2; bus_master_idle = 0; tick();
    enable = 1;
    for (int i = 0; i < 18; i++) begin
      adc_valid = 1; adc_data = 32'h100 + i; tick();
    end
    adc_valid = 0;
    chk("ovf level", 32'(fifo_level), 32'd16);
    chk("ovf flag", 32'(overflow), 32'd1);
    chk("ovf dropped", 32'(dropped_count), 32'd2);
    chk("ovf head", data_wr, 32'h100);
    adc_valid = 1; adc_data = 32'h200; data_done = 1; tick();
    adc_valid = 0;
    chk("full push+pop level", 32'(fifo_level), 32'd16);
    chk("full push+pop dropped", 32'(dropped_count), 32'd2);
    chk("full push+pop head", data_wr, 32'h101);
    for (int i = 2; i < 16; i++) exp_head.push_back(32'h100 + i);
    exp_head.push_back(32'h200);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("drain%0d level", k), 32'(fifo_level), 32'(15 - k));
      if (k < 15) chk($sformatf("drain%0d head", k), data_wr, exp_head[k]);
    end
    tick();
    chk("done on empty level", 32'(fifo_level), 32'd0);
    chk("done on empty flag", 32'(fifo_empty), 32'd1);
    data_done = 0;
    do_reset();
    chk("post-reset overflow", 32'(overflow), 32'd0);

    // Master model: two bursts of three words each
    data_size = 2'd2; threshold = 5'd3; bus_master_idle = 0; enable = 1;
    for (int i = 0; i < 6; i++) begin
      adc_valid = 1; adc_data = 32'h300 + i; tick();
    end
    adc_valid = 0;
    starts = 0; busy = 0; since_idle = 3;
    for (int c = 0; c < 60; c++) begin
      if (busy > 0) begin
        bus_master_idle = 0;
        data_done = (busy == 9 || busy == 6 || busy == 3);
        since_idle = 0;
      end else begin
        bus_master_idle = 1;
        data_done = 0;
        since_idle++;
      end
      tick();
      if (busy > 0) busy--;
      if (start) begin
        starts++;
        chk("start outside burst", 32'(busy), 32'd0);
        chk("hold before start", 32'(since_idle >= 3), 32'd1);
        busy = 10;
      end
    end
    data_done = 0;
    chk("burst count", 32'(starts), 32'd2);
    chk("bursts drained", 32'(fifo_level), 32'd0);
    data_done = 1; tick(); data_done = 0;
    chk("empty done level", 32'(fifo_level), 32'd0);

    // Reset asserted mid-burst with five words queued
    threshold = 5'd5; bus_master_idle = 0;
    for (int i = 0; i < 5; i++) begin
      adc_valid = 1; adc_data = 32'h400 + i; tick();
    end
    adc_valid = 0; bus_master_idle = 1; tick();
    chk("rst-test start", 32'(start), 32'd1);
    bus_master_idle = 0; tick(); tick();
    chk("rst-test level", 32'(fifo_level), 32'd5);
    wb_rst = 1; tick();
    chk_reset_outputs("midburst reset");
    wb_rst = 0; bus_master_idle = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("post-reset start%0d", i), 32'(start), 32'd0);
    end

    // Randomized run against the queue model (master never idle, so no bursts)
    do_reset();
    m_q.delete(); m_pend.delete(); m_ovf = 0; m_drop = 0;
    bus_master_idle = 0; threshold = 5'd1;
    for (int c = 0; c < 1500; c++) begin
      enable = ($urandom_range(0, 24) != 0);
      if (!enable && $urandom_range(0, 1) == 1) data_size = 2'($urandom_range(0, 3));
      adc_valid = ($urandom_range(0, 9) < 7);
      adc_data  = $urandom;
      flush     = ($urandom_range(0, 19) == 0);
      data_done = ($urandom_range(0, 2) == 0);
      model_step(enable, data_size, adc_valid, adc_data, flush, data_done);
      tick();
      chk("rand level", 32'(fifo_level), 32'(m_q.size()));
      chk("rand empty", 32'(fifo_empty), 32'(m_q.size() == 0));
      chk("rand overflow", 32'(overflow), 32'(m_ovf));
      chk("rand dropped", 32'(dropped_count), 32'(m_drop));
      chk("rand start", 32'(start), 32'd0);
      if (m_q.size() > 0) chk("rand head", data_wr, m_q[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
